// File: rtl/axi_mem_arbiter.sv
// Shares one single-beat AXI4 master port between the IFU (read-only) and LSU (read/write).
// Define AXI_MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module axi_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,

    input  logic                    ifu_req,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_ack,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    output logic                    ifu_err,

    input  logic                    lsu_req,
    input  logic                    lsu_we,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    output logic                    lsu_ack,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    lsu_err,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,

    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,

    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic [ID_WIDTH-1:0]     M_AXI_BID,

    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [7:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,

    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic [ID_WIDTH-1:0]     M_AXI_RID
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        DONE
    } state_t;

    state_t state, state_next;

    logic                  owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done, w_done;
    logic [1:0]            resp_q;
    logic                  grant_valid, grant_owner;
    logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                  unused_inputs;

    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;

    // Only one transaction is ever in flight, so response IDs and RLAST carry no information.
    assign unused_inputs = ^{M_AXI_RLAST, M_AXI_RID, M_AXI_BID};

    assign grant_valid = ifu_req || lsu_req;

`ifdef AXI_MEM_ARBITER_RR_EN
    logic last_grant;

    assign grant_owner = (ifu_req && lsu_req) ? ~last_grant : lsu_req;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_owner;
        end
    end
`else
    assign grant_owner = lsu_req;
`endif

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWID    = ID_WIDTH'(owner);
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'($clog2(STRB_WIDTH));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = M_AXI_WVALID;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARID    = ID_WIDTH'(owner);
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'($clog2(STRB_WIDTH));
    assign M_AXI_ARBURST = 2'b01;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        ifu_ack       = 1'b0;
        lsu_ack       = 1'b0;
        ifu_err       = 1'b0;
        lsu_err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_owner && lsu_we) ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (ar_hs) state_next = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (r_hs) state_next = DONE;
            end
            WR_ADDR_DATA: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (b_hs) state_next = DONE;
            end
            DONE: begin
                ifu_ack    = !owner;
                lsu_ack    = owner;
                ifu_err    = !owner && (resp_q != 2'b00);
                lsu_err    = owner && (resp_q != 2'b00);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at grant so later requester changes cannot disturb the bus.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            owner     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            resp_q    <= 2'b00;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner   <= grant_owner;
                        addr_q  <= grant_owner ? lsu_addr : ifu_addr;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        resp_q <= M_AXI_RRESP;
                        if (owner) lsu_rdata <= M_AXI_RDATA;
                        else       ifu_rdata <= M_AXI_RDATA;
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs) resp_q <= M_AXI_BRESP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed testbench for axi_mem_arbiter with a small configurable AXI slave and protocol monitor.
module tb_axi_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int SW = DW / 8;
`ifdef AXI_MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic          ifu_req, ifu_ack, ifu_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req, lsu_we, lsu_ack, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [SW-1:0] lsu_wstrb;

    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          arvalid, arready, rvalid, rready, rlast;

    axi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_ack(lsu_ack),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
        .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp), .M_AXI_BID(bid),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RID(rid)
    );

    always #5 clk = ~clk;

    int            ar_delay, aw_delay, w_delay;
    bit            r_hold, b_hold, r_from_addr;
    logic [DW-1:0] r_data_cfg;
    logic [1:0]    r_resp_cfg, b_resp_cfg;

    int            ar_cnt, aw_cnt, w_cnt, ar_id0_cnt, ar_wait, aw_wait, w_wait;
    logic [AW-1:0] obs_araddr, obs_awaddr;
    logic [IW-1:0] obs_arid, obs_awid;
    logic [7:0]    obs_arlen;
    logic [DW-1:0] obs_wdata;
    logic [SW-1:0] obs_wstrb;
    logic          obs_wlast;
    int            ifu_acks, lsu_acks, viol;
    bit            prev_ack;
    int            total, bad;

    // Slave responses and protocol monitor; all decisions are made mid-cycle for the next edge.
    initial begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rresp = 2'b00; rlast = 0; rid = '0; bresp = 2'b00; bid = '0;
        obs_araddr = '0; obs_arid = '0; obs_awid = '0;
        forever begin
            @(negedge clk);
            arready = arvalid && (ar_wait >= ar_delay);
            awready = awvalid && (aw_wait >= aw_delay);
            wready  = wvalid && (w_wait >= w_delay);
            rvalid  = rready && !r_hold;
            rdata   = r_from_addr ? ~obs_araddr : r_data_cfg;
            rresp   = r_resp_cfg;
            rlast   = rvalid;
            rid     = obs_arid;
            bvalid  = bready && !b_hold;
            bresp   = b_resp_cfg;
            bid     = obs_awid;
            if (arvalid) begin
                if (arready) begin
                    ar_cnt++; ar_wait = 0;
                    obs_araddr = araddr; obs_arid = arid; obs_arlen = arlen;
                    if (arid == '0) ar_id0_cnt++;
                end else ar_wait++;
            end
            if (awvalid) begin
                if (awready) begin
                    aw_cnt++; aw_wait = 0; obs_awaddr = awaddr; obs_awid = awid;
                end else aw_wait++;
            end
            if (wvalid) begin
                if (wready) begin
                    w_cnt++; w_wait = 0; obs_wdata = wdata; obs_wstrb = wstrb; obs_wlast = wlast;
                end else w_wait++;
            end
            if (ifu_ack) ifu_acks++;
            if (lsu_ack) lsu_acks++;
            if (ifu_ack && lsu_ack) viol++;
            if ((ifu_ack || lsu_ack) && prev_ack) viol++;
            if (arvalid && (awvalid || wvalid)) viol++;
            if (wlast !== wvalid) viol++;
            if (bready && (awvalid || wvalid)) viol++;
            prev_ack = rst_n && (ifu_ack || lsu_ack);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_slave;
        ar_delay = 0; aw_delay = 0; w_delay = 0;
        r_hold = 0; b_hold = 0; r_from_addr = 0;
        r_data_cfg = '0; r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_id0_cnt = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
    endtask

    task automatic wait_ack(input bit lsu, output bit got);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (lsu ? lsu_ack : ifu_ack) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({arvalid, awvalid, wvalid, rready, bready, ifu_ack, lsu_ack, ifu_err, lsu_err} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000000",
                     {arvalid, awvalid, wvalid, rready, bready, ifu_ack, lsu_ack, ifu_err, lsu_err});
        end
        total++;
        if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", ifu_rdata, lsu_rdata);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({arvalid, awvalid, wvalid} !== 3'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got %b expected 000", {arvalid, awvalid, wvalid});
        end
        total++;
        if ({arlen, arsize, arburst, awlen, awsize, awburst} !== {8'd0, 3'd2, 2'b01, 8'd0, 3'd2, 2'b01}) begin
            bad++;
            $display("[TB] FAIL axi_consts: got %h expected %h", {arlen, arsize, arburst, awlen, awsize, awburst},
                     {8'd0, 3'd2, 2'b01, 8'd0, 3'd2, 2'b01});
        end
    endtask

    task automatic test_ifu_read;
        bit got;
        int lsu_base;
        clear_slave();
        ar_delay = 2;
        r_data_cfg = 32'h0050_0093;
        lsu_base = lsu_acks;
        ifu_addr = 32'h8000_0010;
        ifu_req = 1;
        tick();
        total++;
        if (arvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL grant_latency: arvalid got %b expected 1", arvalid);
        end
        wait_ack(0, got);
        ifu_req = 0;
        total++;
        if (!got) begin bad++; $display("[TB] FAIL ifu_read_ack: got no ack expected ack"); end
        total++;
        if (ifu_rdata !== 32'h0050_0093 || ifu_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ifu_read_data: got %h err %b expected 00500093 err 0", ifu_rdata, ifu_err);
        end
        total++;
        if (obs_araddr !== 32'h8000_0010 || obs_arid !== 1'b0 || obs_arlen !== 8'd0 || ar_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL ifu_read_ar: got addr %h id %h len %h cnt %0d expected 80000010 0 00 1",
                     obs_araddr, obs_arid, obs_arlen, ar_cnt);
        end
        total++;
        if (lsu_acks !== lsu_base) begin
            bad++;
            $display("[TB] FAIL ifu_read_no_lsu_ack: got %0d expected %0d", lsu_acks, lsu_base);
        end
        tick();
        total++;
        if (ifu_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ifu_ack_pulse: got %b expected 0", ifu_ack);
        end
    endtask

    task automatic test_lsu_write;
        bit got, bready_early;
        int ifu_base;
        clear_slave();
        aw_delay = 3;
        ifu_base = ifu_acks;
        lsu_we = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        lsu_req = 1;
        got = 0; bready_early = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bready && (aw_cnt != 1 || w_cnt != 1)) bready_early = 1;
            if (lsu_ack) begin got = 1; break; end
        end
        lsu_req = 0;
        total++;
        if (!got) begin bad++; $display("[TB] FAIL lsu_write_ack: got no ack expected ack"); end
        total++;
        if (aw_cnt !== 1 || w_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL lsu_write_hs: got aw %0d w %0d expected 1 1", aw_cnt, w_cnt);
        end
        total++;
        if (obs_awaddr !== 32'h8000_1000 || obs_awid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lsu_write_aw: got %h id %h expected 80001000 1", obs_awaddr, obs_awid);
        end
        total++;
        if (obs_wdata !== 32'hDEAD_BEEF || obs_wstrb !== 4'hF || obs_wlast !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lsu_write_w: got %h %h %b expected deadbeef f 1", obs_wdata, obs_wstrb, obs_wlast);
        end
        total++;
        if (bready_early !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bready_order: got early=%b expected 0", bready_early);
        end
        total++;
        if (lsu_err !== 1'b0 || ifu_acks !== ifu_base) begin
            bad++;
            $display("[TB] FAIL lsu_write_err: got err %b ifu_acks %0d expected 0 %0d", lsu_err, ifu_acks, ifu_base);
        end
    endtask

    task automatic test_tie;
        bit got, first_lsu;
        clear_slave();
        r_from_addr = 1;
        first_lsu = !RR;
        ifu_addr = 32'h8000_0020;
        lsu_we = 0; lsu_addr = 32'h8000_2000;
        ifu_req = 1; lsu_req = 1;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ifu_ack || lsu_ack) begin got = 1; break; end
        end
        total++;
        if (!got || lsu_ack !== first_lsu || ifu_ack !== !first_lsu) begin
            bad++;
            $display("[TB] FAIL tie_first: got ifu %b lsu %b expected lsu=%b", ifu_ack, lsu_ack, first_lsu);
        end
        if (first_lsu) lsu_req = 0; else ifu_req = 0;
        wait_ack(!first_lsu, got);
        ifu_req = 0; lsu_req = 0;
        total++;
        if (!got) begin bad++; $display("[TB] FAIL tie_second: got no ack expected ack"); end
        total++;
        if (ifu_rdata !== 32'h7FFF_FFDF || lsu_rdata !== 32'h7FFF_DFFF) begin
            bad++;
            $display("[TB] FAIL tie_data: got %h/%h expected 7fffffdf/7fffdfff", ifu_rdata, lsu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int n, order_bad, n_ifu, n_lsu, viol_base;
        bit exp_lsu;
        clear_slave();
        r_data_cfg = 32'h0000_0013;
        viol_base = viol;
        ifu_addr = 32'h8000_0040;
        lsu_we = 1; lsu_addr = 32'h8000_3000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
        ifu_req = 1; lsu_req = 1;
        n = 0; order_bad = 0; n_ifu = 0; n_lsu = 0;
        for (int i = 0; i < 300 && n < 10; i++) begin
            tick();
            if (ifu_ack || lsu_ack) begin
                exp_lsu = RR ? ((n % 2) == 1) : 1'b1;
                if (lsu_ack !== exp_lsu) order_bad++;
                if (ifu_ack) n_ifu++;
                if (lsu_ack) n_lsu++;
                n++;
            end
        end
        ifu_req = 0; lsu_req = 0;
        tick(); tick();
        total++;
        if (n !== 10) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 10", n); end
        total++;
        if (order_bad !== 0) begin bad++; $display("[TB] FAIL b2b_order: got %0d wrong expected 0", order_bad); end
        total++;
        if (n_ifu !== (RR ? 5 : 0) || n_lsu !== (RR ? 5 : 10)) begin
            bad++;
            $display("[TB] FAIL b2b_split: got ifu %0d lsu %0d expected %0d %0d", n_ifu, n_lsu, RR ? 5 : 0, RR ? 5 : 10);
        end
        total++;
        if (ar_id0_cnt !== n_ifu || aw_cnt !== n_lsu || w_cnt !== n_lsu) begin
            bad++;
            $display("[TB] FAIL b2b_grants: got ar0 %0d aw %0d w %0d expected %0d %0d %0d",
                     ar_id0_cnt, aw_cnt, w_cnt, n_ifu, n_lsu, n_lsu);
        end
        total++;
        if (viol !== viol_base) begin
            bad++;
            $display("[TB] FAIL b2b_protocol: got %0d violations expected 0", viol - viol_base);
        end
    endtask

    task automatic test_error;
        bit got;
        clear_slave();
        r_resp_cfg = 2'b10;
        r_data_cfg = 32'hBADC_0DE0;
        lsu_we = 0; lsu_addr = 32'h8000_4000; lsu_req = 1;
        wait_ack(1, got);
        lsu_req = 0;
        total++;
        if (!got || lsu_err !== 1'b1 || lsu_rdata !== 32'hBADC_0DE0) begin
            bad++;
            $display("[TB] FAIL slverr: got ack %b err %b data %h expected 1 1 badc0de0", got, lsu_err, lsu_rdata);
        end
        tick();
        total++;
        if (lsu_err !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse: got %b expected 0", lsu_err); end
        r_resp_cfg = 2'b00;
        r_data_cfg = 32'h00A0_0113;
        ifu_addr = 32'h8000_0050; ifu_req = 1;
        wait_ack(0, got);
        ifu_req = 0;
        total++;
        if (!got || ifu_err !== 1'b0 || ifu_rdata !== 32'h00A0_0113) begin
            bad++;
            $display("[TB] FAIL okay_after_err: got ack %b err %b data %h expected 1 0 00a00113", got, ifu_err, ifu_rdata);
        end
        total++;
        if (lsu_rdata !== 32'hBADC_0DE0) begin
            bad++;
            $display("[TB] FAIL rdata_hold: got %h expected badc0de0", lsu_rdata);
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        int ack_base;
        clear_slave();
        r_hold = 1;
        r_data_cfg = 32'h00C0_0193;
        ifu_addr = 32'h8000_0060; ifu_req = 1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rready) begin got = 1; break; end
        end
        total++;
        if (!got) begin bad++; $display("[TB] FAIL reach_rd_data: got no rready expected rready"); end
        ack_base = ifu_acks;
        rst_n = 0;
        #1;
        total++;
        if ({arvalid, rready, ifu_ack, lsu_ack} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b expected 0000", {arvalid, rready, ifu_ack, lsu_ack});
        end
        tick(); tick();
        total++;
        if (ifu_acks !== ack_base || ifu_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_abort: got acks %0d rdata %h expected %0d 0", ifu_acks, ifu_rdata, ack_base);
        end
        rst_n = 1;
        r_hold = 0;
        wait_ack(0, got);
        ifu_req = 0;
        total++;
        if (!got || ifu_rdata !== 32'h00C0_0193 || ifu_err !== 1'b0 || ar_cnt !== 2) begin
            bad++;
            $display("[TB] FAIL after_reset_read: got ack %b data %h err %b ar %0d expected 1 00c00193 0 2",
                     got, ifu_rdata, ifu_err, ar_cnt);
        end
        tick();
    endtask

    initial begin
        total = 0; bad = 0; viol = 0; ifu_acks = 0; lsu_acks = 0; prev_ack = 0;
        ifu_req = 0; ifu_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
        clear_slave();
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_tie();
        test_back_to_back();
        test_error();
        test_reset_mid();
        total++;
        if (viol !== 0) begin bad++; $display("[TB] FAIL protocol_total: got %0d violations expected 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Shares one AXI4 master port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the RISC-V core.
- Single-beat transactions only (LEN=0, INCR), one outstanding transaction at a time.
- Sits between the core's simple req/ack memory ports and the AXI interconnect / SoC memory.

Parameters:
- ADDR_WIDTH, 32, address width on both requester ports and AXI.
- DATA_WIDTH, 32, data width; WSTRB is DATA_WIDTH/8 bits.
- ID_WIDTH, 1, AXI ID width; IFU uses ID 0, LSU uses ID 1 (bit 0; upper bits zero).

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- ifu_req  in  1  fetch request; held high until ifu_ack.
- ifu_addr  in  ADDR_WIDTH  fetch address.
- ifu_ack  out  1  one-cycle pulse: ifu_rdata/ifu_err valid.
- ifu_rdata  out  DATA_WIDTH  fetched word.
- ifu_err  out  1  RRESP!=OKAY, valid with ifu_ack.
- lsu_req  in  1  data request; held high until lsu_ack.
- lsu_we  in  1  1=write, 0=read.
- lsu_addr  in  ADDR_WIDTH  data address.
- lsu_wdata  in  DATA_WIDTH  write data.
- lsu_wstrb  in  DATA_WIDTH/8  byte strobes.
- lsu_ack  out  1  one-cycle completion pulse.
- lsu_rdata  out  DATA_WIDTH  load data, valid with lsu_ack on reads.
- lsu_err  out  1  RRESP/BRESP!=OKAY, valid with lsu_ack.
- M_AXI_AW*: AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH, AWID out ID_WIDTH, AWLEN out 8, AWSIZE out 3, AWBURST out 2.
- M_AXI_W*: WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8, WLAST out 1.
- M_AXI_B*: BVALID in 1, BREADY out 1, BRESP in 2, BID in ID_WIDTH.
- M_AXI_AR*: ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH, ARID out ID_WIDTH, ARLEN out 8, ARSIZE out 3, ARBURST out 2.
- M_AXI_R*: RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2, RLAST in 1, RID in ID_WIDTH.

Behaviour:
- Constants: AxLEN=0, AxBURST=01, AxSIZE=log2(DATA_WIDTH/8), WLAST=WVALID.
- Reset (async, ARESETN low): state=IDLE. All VALIDs, RREADY, BREADY, acks and errs = 0. rdata outputs = 0. Grant owner = IFU.
- Reset mid-transaction aborts it silently: no ack is issued, and requesters re-present the request after reset.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
- IDLE:
  - Sample ifu_req and lsu_req. Fixed priority: LSU wins on simultaneous requests.
  - On grant, register owner, addr, we, wdata and wstrb; AXI outputs are driven only from these registers.
  - A read goes to RD_ADDR with ARVALID=1 next cycle. A write goes to WR_ADDR_DATA with AWVALID=1 and WVALID=1 next cycle.
  - Grant-to-VALID latency is 1 cycle.
- RD_ADDR: hold ARVALID/ARADDR/ARID stable until ARREADY. On handshake, ARVALID=0 and RREADY=1, then go to RD_DATA.
- RD_DATA: on RVALID&&RREADY, capture RDATA and RRESP, set RREADY=0, go to DONE. Ignore RVALID while not in RD_DATA.
- WR_ADDR_DATA:
  - AW and W are independent. Each VALID drops on its own handshake; internal aw_done and w_done flags record completion.
  - Both handshakes may occur in the same cycle, or in either order.
  - When both are done, set BREADY=1 and go to WR_RESP.
- WR_RESP: on BVALID, capture BRESP, set BREADY=0, go to DONE.
- DONE:
  - Pulse the owner's ack for exactly one cycle. err = (resp!=2'b00). rdata is held until the next ack to the same requester.
  - Return to IDLE. A still-high req is not re-granted in the DONE cycle.
  - Minimum spacing between acks is 1 idle cycle.
- Requester changing addr/data while req is high and not yet acked is a protocol violation; the arbiter uses only the registered copy.
- A requester never receives an ack for a transaction it did not own. The non-owner's ack is 0 throughout.

Optional Feature:
- Macro: AXI_MEM_ARBITER_RR_EN.
- Defined: round-robin arbitration on simultaneous requests. The requester that did not receive the last grant wins. Initial last-grant = LSU, so IFU wins the first tie after reset.
- Undefined: fixed priority, LSU over IFU. The last-grant register is not implemented.

Test Plan:
- ifu_req, addr 0x80000010; slave ARREADY after 2 cycles, RDATA 0x00500093 OKAY -> ARADDR=0x80000010, ARID=0, ARLEN=0; ifu_ack 1 cycle with ifu_rdata=0x00500093, ifu_err=0; lsu_ack stays 0.
- lsu write, addr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF; WREADY 3 cycles before AWREADY; BRESP=OKAY -> AW and W each handshake once, WLAST=1, BREADY only after both; lsu_ack once, lsu_err=0.
- ifu_req and lsu_req (read, 0x80002000) rise in the same cycle, fixed priority -> LSU read completes first, then IFU. With RR_EN -> IFU first, then on the next tie LSU.
- LSU read with RRESP=2'b10 (SLVERR) -> lsu_ack with lsu_err=1. Next IFU read with OKAY -> ifu_err=0.
- Assert ARESETN low during RD_DATA -> ARVALID/RREADY/acks go 0 immediately (async). After release the FSM is in IDLE and the re-presented request completes normally.
- Both requesters held high for 10 transactions with zero-wait slave -> every transaction separated by at least 1 idle cycle, never two VALIDs from different owners, ack counts match grant counts.
